debounce_ctrl: RTL

Multi-channel input conditioner for asynchronous board-level signals (push-buttons, switches) feeding the TinyRV1 I/O path. Each channel passes its raw input through a two-flop synchronizer, then a debounce state machine that accepts a new level only after it has held stable for a programmable number of cycles. On each accepted change the channel emits a one-cycle rise or fall pulse. Software-visible I/O logic consumes the clean level and pulses instead of touching raw pins.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_chan.sv | 112 +++++++++++
 rtl/debounce_ctrl.sv | 30 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel input debouncer.
package debounce_pkg;

   localparam int unsigned DEFAULT_N      = 4;
   localparam int unsigned DEFAULT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } debounce_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, acceptance FSM with stability
// counter, and registered level / rise / fall outputs.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned CYCLES = DEFAULT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic            meta;
   logic            sync;
   debounce_state_t state;
   debounce_state_t state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            level_nxt;
   logic            rise_nxt;
   logic            fall_nxt;

   // Two-flop synchronizer; resets to 0 so the first FSM evaluation sees a low input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= in_raw;
         sync <= meta;
      end
   end

   // State, counter and output registers; reset aborts any wait without a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE_LO;
         cnt   <= CNT_ZERO;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

   // Next-state logic: a new level is accepted only after CYCLES+1 steady samples.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LO: begin
            if (sync) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!sync) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == CNT_MAX) begin
               state_nxt = IDLE_HI;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
               cnt_nxt   = CNT_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         IDLE_HI: begin
            if (!sync) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (sync) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == CNT_MAX) begin
               state_nxt = IDLE_LO;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
               cnt_nxt   = CNT_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE_LO;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel debouncer: N independent channels, no shared state.
module debounce_ctrl
   import debounce_pkg::*;
#(
   parameter int unsigned N      = DEFAULT_N,
   parameter int unsigned CYCLES = DEFAULT_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_raw,
   output logic [N-1:0] level,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   // One debounce channel per input bit.
   for (genvar i = 0; i < N; i++) begin : g_chan
      debounce_chan #(
         .CYCLES (CYCLES)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .in_raw (in_raw[i]),
         .level  (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

endmodule
